// File: rtl/servo_pkg.sv
// Shared types, widths and default constants for the two-joint servo PWM driver.
package servo_pkg;

  localparam int CNT_W  = 21;
  localparam int PROD_W = 42;

  typedef logic [23:0]      angle_t;
  typedef logic [CNT_W-1:0] pulse_t;

  localparam angle_t ANG_MAX = 24'hB40000;

  localparam int DEF_PERIOD_CYCLES = 2000000;
  localparam int DEF_MIN_PULSE     = 100000;
  localparam int DEF_MID_PULSE     = 150000;
  localparam int DEF_SCALE_Q       = 142222;
  localparam int DEF_MAX_STEP      = 2000;

  // Move cur toward tgt by at most step, landing exactly on tgt when close enough.
  function automatic pulse_t slewStep(input pulse_t cur, input pulse_t tgt, input pulse_t step);
    if (tgt >= cur) begin
      return ((tgt - cur) <= step) ? tgt : cur + step;
    end
    return ((cur - tgt) <= step) ? tgt : cur - step;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo joint: clamp/scale pipeline, per-frame slew-limited width and PWM compare.
module servo_channel
  import servo_pkg::*;
#(
  parameter int MIN_PULSE = DEF_MIN_PULSE,
  parameter int MID_PULSE = DEF_MID_PULSE,
  parameter int SCALE_Q   = DEF_SCALE_Q,
  parameter int MAX_STEP  = DEF_MAX_STEP
) (
  input  logic   clk,
  input  logic   reset,
  input  pulse_t cnt_i,
  input  logic   update_i,
  input  logic   en_i,
  input  angle_t angle_i,
  output logic   pwm_o,
  output logic   at_target_o
);

  angle_t              clamp_q, clamp_d;
  pulse_t              target_q, target_d;
  pulse_t              cur_q, cur_d;
  pulse_t              slewed;
  logic                pwm_q;
  logic [PROD_W-1:0]   prod;

  always_comb begin
    clamp_d  = (angle_i > ANG_MAX) ? ANG_MAX : angle_i;
    prod     = PROD_W'(clamp_q) * PROD_W'(SCALE_Q);
    target_d = pulse_t'(MIN_PULSE) + pulse_t'(prod >> 24);
    slewed   = slewStep(cur_q, target_q, pulse_t'(MAX_STEP));
    cur_d    = update_i ? slewed : cur_q;
  end

  // The width only moves on the last cycle of a frame, so pulses never change mid-frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      clamp_q  <= '0;
      target_q <= pulse_t'(MID_PULSE);
      cur_q    <= pulse_t'(MID_PULSE);
      pwm_q    <= 1'b0;
    end else begin
      clamp_q  <= clamp_d;
      target_q <= target_d;
      cur_q    <= cur_d;
      pwm_q    <= en_i && (cnt_i < cur_q);
    end
  end

  assign pwm_o       = pwm_q;
  assign at_target_o = (slewed == target_q);

endmodule

// File: rtl/servo_pwm_driver.sv
// Shoulder/elbow hobby-servo PWM driver with a shared 20 ms frame counter.
module servo_pwm_driver
  import servo_pkg::*;
#(
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int MIN_PULSE     = DEF_MIN_PULSE,
  parameter int MID_PULSE     = DEF_MID_PULSE,
  parameter int SCALE_Q       = DEF_SCALE_Q,
  parameter int MAX_STEP      = DEF_MAX_STEP
) (
  input  logic   clk,
  input  logic   reset,
  input  angle_t shoulder_angle,
  input  angle_t elbow_angle,
  output logic   pwm_shoulder,
  output logic   pwm_elbow,
  output logic   frame_start,
  output logic   settled
);

  pulse_t cnt_q, cnt_d;
  logic   run_q;
  logic   frameStart_q;
  logic   settled_q;
  logic   update;
  logic   shAtTarget, elAtTarget;

  // The counter holds at 0 for one cycle after reset so frame_start can announce frame 0.
  always_comb begin
    update = run_q && (cnt_q == pulse_t'(PERIOD_CYCLES - 1));
    if (!run_q || update) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + pulse_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      run_q        <= 1'b0;
      frameStart_q <= 1'b0;
      settled_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      run_q        <= 1'b1;
      frameStart_q <= (cnt_d == '0);
      if (update) begin
        settled_q <= shAtTarget && elAtTarget;
      end
    end
  end

  servo_channel #(
    .MIN_PULSE (MIN_PULSE),
    .MID_PULSE (MID_PULSE),
    .SCALE_Q   (SCALE_Q),
    .MAX_STEP  (MAX_STEP)
  ) shoulderCh (
    .clk         (clk),
    .reset       (reset),
    .cnt_i       (cnt_q),
    .update_i    (update),
    .en_i        (run_q),
    .angle_i     (shoulder_angle),
    .pwm_o       (pwm_shoulder),
    .at_target_o (shAtTarget)
  );

  servo_channel #(
    .MIN_PULSE (MIN_PULSE),
    .MID_PULSE (MID_PULSE),
    .SCALE_Q   (SCALE_Q),
    .MAX_STEP  (MAX_STEP)
  ) elbowCh (
    .clk         (clk),
    .reset       (reset),
    .cnt_i       (cnt_q),
    .update_i    (update),
    .en_i        (run_q),
    .angle_i     (elbow_angle),
    .pwm_o       (pwm_elbow),
    .at_target_o (elAtTarget)
  );

  assign frame_start = frameStart_q;
  assign settled     = settled_q;

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Self-checking bench: measures each frame's pulse widths and compares against an angle/slew model.
module tb_servo_pwm_driver;

  localparam int P     = 250;
  localparam int MINP  = 100;
  localparam int MIDP  = 150;
  localparam int SCL   = 142;
  localparam int STEP  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] shoulderAngle = 24'h0;
  logic [23:0] elbowAngle = 24'h0;
  logic        pwmShoulder, pwmElbow, frameStart, settled;

  int nChecks = 0;
  int nFail = 0;
  int modelSh, modelEl;
  int modelSettled;
  int lastSh, lastEl;

  typedef struct {
    logic [23:0] angSh;
    logic [23:0] angEl;
    int          expSh;
    int          expEl;
  } vec_t;

  vec_t vecs[4];

  servo_pwm_driver #(
    .PERIOD_CYCLES (P),
    .MIN_PULSE     (MINP),
    .MID_PULSE     (MIDP),
    .SCALE_Q       (SCL),
    .MAX_STEP      (STEP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .shoulder_angle (shoulderAngle),
    .elbow_angle    (elbowAngle),
    .pwm_shoulder   (pwmShoulder),
    .pwm_elbow      (pwmElbow),
    .frame_start    (frameStart),
    .settled        (settled)
  );

  always #5 clk = ~clk;

  // Hang guard: a stuck design still produces a visible failure instead of running forever.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no end, required end");
    $fatal(1, "[TB] watchdog");
  end

  // Width a servo should settle at for a given Q8.16 angle.
  function automatic int targetOf(input logic [23:0] a);
    longint c;
    c = longint'(a);
    if (c > 64'd11796480) c = 11796480;
    return MINP + int'((c * SCL) / 16777216);
  endfunction

  function automatic int slewModel(input int cur, input int tgt);
    int diff;
    diff = tgt - cur;
    if (diff <= STEP && diff >= -STEP) return tgt;
    return (diff > 0) ? cur + STEP : cur - STEP;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] sh, input logic [23:0] el);
    shoulderAngle = sh;
    elbowAngle    = el;
  endtask

  task automatic doReset(input logic [23:0] sh, input logic [23:0] el);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(sh, el);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset pwm_shoulder", int'(pwmShoulder), 0);
      checkOutput("reset pwm_elbow", int'(pwmElbow), 0);
      checkOutput("reset frame_start", int'(frameStart), 0);
      checkOutput("reset settled", int'(settled), 0);
    end
    reset = 1'b0;
    @(negedge clk);
    checkOutput("frame_start after release", int'(frameStart), 1);
    modelSh = MIDP;
    modelEl = MIDP;
    modelSettled = 0;
  endtask

  // One frame from its frame_start cycle through cnt = P-1; optional angle change at cycle chgIdx.
  task automatic runFrame(input logic [23:0] nSh, input logic [23:0] nEl, input int chgIdx);
    int k;
    int hSh, hEl, fsCnt;
    logic [23:0] oldSh, oldEl, useSh, useEl;
    int tSh, tEl;
    k = 0;
    hSh = 0;
    hEl = 0;
    fsCnt = 0;
    while (frameStart !== 1'b1 && k < P + 5) begin
      @(negedge clk);
      k++;
    end
    if (frameStart !== 1'b1) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL frame_start timeout: got none in %0d cycles, required one", P + 5);
      return;
    end
    checkOutput("settled", int'(settled), modelSettled);
    oldSh = shoulderAngle;
    oldEl = elbowAngle;
    for (int i = 0; i < P; i++) begin
      if (i > 0) @(negedge clk);
      hSh += int'(pwmShoulder);
      hEl += int'(pwmElbow);
      fsCnt += int'(frameStart);
      if (i == chgIdx) applyStimulus(nSh, nEl);
    end
    checkOutput("shoulder width", hSh, modelSh);
    checkOutput("elbow width", hEl, modelEl);
    checkOutput("frame_start pulses per frame", fsCnt, 1);
    lastSh = hSh;
    lastEl = hEl;
    useSh = (chgIdx >= 0 && chgIdx <= P - 3) ? nSh : oldSh;
    useEl = (chgIdx >= 0 && chgIdx <= P - 3) ? nEl : oldEl;
    tSh = targetOf(useSh);
    tEl = targetOf(useEl);
    modelSh = slewModel(modelSh, tSh);
    modelEl = slewModel(modelEl, tEl);
    modelSettled = (modelSh == tSh && modelEl == tEl) ? 1 : 0;
  endtask

  initial begin
    int expSh, expEl, f;
    logic [23:0] rSh, rEl;
    int mode, idx;

    vecs[0] = '{24'h2D0000, 24'h870000, 124, 174};
    vecs[1] = '{24'h010000, 24'h5A0000, 100, 149};
    vecs[2] = '{24'h870000, 24'h010000, 174, 100};
    vecs[3] = '{24'hFFFFFF, 24'h000000, 199, 100};

    // 90 degrees on both joints: mid width first, then 149 with settled.
    doReset(24'h5A0000, 24'h5A0000);
    for (int k = 0; k < 3; k++) begin
      runFrame(24'h0, 24'h0, -1);
      checkOutput("90deg shoulder", lastSh, (k == 0) ? 150 : 149);
      checkOutput("90deg elbow", lastEl, (k == 0) ? 150 : 149);
    end
    checkOutput("90deg settled", int'(settled), 1);

    // Angle change one cycle before the update is deferred by one frame.
    runFrame(24'hB40000, 24'h5A0000, P - 2);
    runFrame(24'h0, 24'h0, -1);
    checkOutput("late change old target", lastSh, 149);
    runFrame(24'h0, 24'h0, -1);
    checkOutput("late change new target", lastSh, 151);

    // Full-scale and over-range shoulder: identical slew sequence.
    for (int t = 0; t < 2; t++) begin
      doReset((t == 0) ? 24'hB40000 : 24'hFFFFFF, 24'h5A0000);
      for (int k = 0; k < 26; k++) begin
        runFrame(24'h0, 24'h0, -1);
        checkOutput("slew up shoulder", lastSh, (k == 0) ? 150 : ((k < 25) ? 150 + 2 * k : 199));
      end
      checkOutput("slew up settled", int'(settled), 1);
    end

    // Opposite-direction slews on the two joints at once.
    doReset(24'h000000, 24'hB40000);
    for (int k = 0; k < 26; k++) begin
      runFrame(24'h0, 24'h0, -1);
      checkOutput("opposite shoulder", lastSh, 150 - 2 * k);
      checkOutput("opposite elbow", lastEl, (k < 25) ? 150 + 2 * k : 199);
    end
    checkOutput("opposite settled", int'(settled), 1);

    // Reset in the middle of a frame while both pulses are high.
    f = 0;
    @(negedge clk);
    while (frameStart !== 1'b1 && f < P + 5) begin
      @(negedge clk);
      f++;
    end
    repeat (50) @(negedge clk);
    checkOutput("pre-abort pwm_shoulder", int'(pwmShoulder), 1);
    checkOutput("pre-abort pwm_elbow", int'(pwmElbow), 1);
    doReset(24'h5A0000, 24'h5A0000);
    runFrame(24'h0, 24'h0, -1);
    checkOutput("post-abort shoulder", lastSh, 150);
    checkOutput("post-abort elbow", lastEl, 150);

    // Table of angle pairs and the widths they must eventually settle to.
    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].angSh, vecs[v].angEl);
      f = 0;
      do begin
        runFrame(24'h0, 24'h0, -1);
        f++;
      end while (!(lastSh == vecs[v].expSh && lastEl == vecs[v].expEl) && f < 60);
      checkOutput("table shoulder", lastSh, vecs[v].expSh);
      checkOutput("table elbow", lastEl, vecs[v].expEl);
      checkOutput("table settled", int'(settled), 1);
    end

    // Random angles changed at random points in the frame.
    for (int r = 0; r < 15; r++) begin
      rSh = 24'($urandom_range(0, 32'hC80000));
      rEl = 24'($urandom_range(0, 32'hC80000));
      mode = int'($urandom_range(0, 2));
      idx = (mode == 0) ? 0 : ((mode == 1) ? P - 2 : int'($urandom_range(1, P - 1)));
      runFrame(rSh, rEl, idx);
    end

    expSh = modelSh;
    expEl = modelEl;
    runFrame(24'h0, 24'h0, -1);
    checkOutput("final shoulder", lastSh, expSh);
    checkOutput("final elbow", lastEl, expEl);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
